// File: rtl/fetch_line_buffer.sv
// Single-line instruction fetch buffer: serves hits from an 8-word line, refills misses with one 8-beat Wishbone burst.
// Optional feature macro FETCH_EARLY_RESTART_EN: answer the waiting request on its own beat while the burst continues.
module fetch_line_buffer #(
   parameter int RW         = 16,
   parameter int AW         = 24,
   parameter int LINE_WORDS = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          req_valid,
   input  logic [AW-1:0] req_addr,
   input  logic          flush,
   output logic          o_ack,
   output logic [RW-1:0] o_data,
   output logic          o_err,
   output logic          wb_cyc,
   output logic          wb_stb,
   output logic [AW-1:0] wb_adr,
   output logic          wb_8_burst,
   input  logic          wb_ack,
   input  logic          wb_err,
   input  logic [RW-1:0] wb_i_dat
);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   line_q [LINE_WORDS];
   logic [RW-1:0]   line_d [LINE_WORDS];
   logic [AW-4:0]   tag_q, tag_d;
   logic            valid_q, valid_d;
   logic [2:0]      beat_q, beat_d;
   logic            pend_flush_q, pend_flush_d;
   logic            served_q, served_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic [RW-1:0]   data_q, data_d;

   logic [AW-4:0]   req_tag;
   logic [2:0]      req_off;
   logic            hit;
   logic            drop_line;

   assign req_tag   = req_addr[AW-1:3];
   assign req_off   = req_addr[2:0];
   assign hit       = valid_q && (tag_q == req_tag);
   assign drop_line = pend_flush_q || flush;

   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      tag_d        = tag_q;
      valid_d      = valid_q;
      beat_d       = beat_q;
      pend_flush_d = pend_flush_q;
      served_d     = served_q;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      data_d       = data_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && !ack_q) begin
               if (hit) begin
                  ack_d  = 1'b1;
                  data_d = line_q[req_off];
               end else begin
                  state_d      = S_FILL;
                  beat_d       = 3'd0;
                  valid_d      = 1'b0;
                  tag_d        = req_tag;
                  served_d     = 1'b0;
                  pend_flush_d = 1'b0;
               end
            end
            // A hit in the same cycle as a flush still returns the old word.
            if (flush) valid_d = 1'b0;
         end
         S_FILL: begin
            if (flush) pend_flush_d = 1'b1;
            if (wb_err) begin
               state_d      = S_IDLE;
               valid_d      = 1'b0;
               pend_flush_d = 1'b0;
               if (!served_q && req_valid) begin
                  ack_d = 1'b1;
                  err_d = 1'b1;
               end
            end else if (wb_ack) begin
               line_d[beat_q] = wb_i_dat;
               beat_d         = beat_q + 3'd1;
`ifdef FETCH_EARLY_RESTART_EN
               if (!served_q && req_valid && req_tag == tag_q && beat_q == req_off) begin
                  ack_d    = 1'b1;
                  data_d   = wb_i_dat;
                  served_d = 1'b1;
               end
`endif
               if (beat_q == 3'd7) begin
                  state_d      = S_IDLE;
                  valid_d      = !drop_line;
                  pend_flush_d = 1'b0;
                  // The line is discarded, so a still-waiting request is answered straight from the fill.
                  if (drop_line && !served_q && req_valid && req_tag == tag_q) begin
                     ack_d    = 1'b1;
                     data_d   = (req_off == 3'd7) ? wb_i_dat : line_q[req_off];
                     served_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         tag_q        <= '0;
         valid_q      <= 1'b0;
         beat_q       <= 3'd0;
         pend_flush_q <= 1'b0;
         served_q     <= 1'b0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         valid_q      <= valid_d;
         beat_q       <= beat_d;
         pend_flush_q <= pend_flush_d;
         served_q     <= served_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         data_q       <= data_d;
      end
   end

   always_ff @(posedge i_clk) begin
      line_q <= line_d;
   end

   assign o_ack      = ack_q;
   assign o_err      = err_q;
   assign o_data     = data_q;
   assign wb_cyc     = (state_q == S_FILL);
   assign wb_stb     = (state_q == S_FILL);
   assign wb_8_burst = (state_q == S_FILL);
   assign wb_adr     = (state_q == S_FILL) ? {tag_q, beat_q} : '0;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Self-checking bench for fetch_line_buffer: directed scenarios plus randomized fetches against a line-level model.
module tb_fetch_line_buffer;
   localparam int RW = 16;
   localparam int AW = 24;
`ifdef FETCH_EARLY_RESTART_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b0;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          flush = 1'b0;
   logic          o_ack, o_err, wb_cyc, wb_stb, wb_8_burst;
   logic [RW-1:0] o_data;
   logic [AW-1:0] wb_adr;
   logic          wb_ack = 1'b0;
   logic          wb_err = 1'b0;
   logic [RW-1:0] wb_i_dat = '0;

   fetch_line_buffer #(.RW(RW), .AW(AW), .LINE_WORDS(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
      .o_ack(o_ack), .o_data(o_data), .o_err(o_err),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_8_burst(wb_8_burst),
      .wb_ack(wb_ack), .wb_err(wb_err), .wb_i_dat(wb_i_dat)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one cached line, contents as delivered by the last clean burst.
   bit            m_valid = 1'b0;
   logic [AW-4:0] m_tag   = '0;
   logic [RW-1:0] m_line [8];
   logic [RW-1:0] salt    = 16'hA000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] mem(input logic [AW-1:0] a);
      return salt + RW'(a[2:0]);
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic flush_idle();
      flush = 1'b1;
      step();
      flush = 1'b0;
      m_valid = 1'b0;
   endtask

   // One fetch; err_beat/flush_beat/rst_beat = beat index at which the event happens, -1 none, flush_beat -2 = with the request.
   task automatic fetch(input logic [AW-1:0] a, input int waits, input int err_beat, input int flush_beat, input int rst_beat);
      logic [AW-1:0] base;
      logic [AW-4:0] t;
      logic [RW-1:0] fill_line [8];
      logic [RW-1:0] ack_data, exp_data;
      int off, obs, beats, wcnt, acks, ack_obs, quiet, rst_obs;
      int drive_off, drive_last, err_drive, exp_obs, exp_acks;
      bit hit, prev_ack, saw_cyc, flushed, rst_done, ack_err, err_hit, served_early, exp_err;
      base = {a[AW-1:3], 3'b000};
      t = a[AW-1:3];
      off = int'(a[2:0]);
      hit = m_valid && (m_tag == t);
      exp_data = hit ? m_line[off] : mem(a);
      obs = 0; beats = 0; wcnt = 0; acks = 0; ack_obs = -1; quiet = 0; rst_obs = -1;
      drive_off = -1; drive_last = -1; err_drive = -1; ack_data = '0;
      prev_ack = 1'b0; saw_cyc = 1'b0; flushed = 1'b0; rst_done = 1'b0; ack_err = 1'b0;
      req_addr = a;
      req_valid = 1'b1;
      while (quiet < 4 && obs < 600) begin
         if (obs > 0) begin
            if (o_ack) begin
               check("ack_gap", 32'(prev_ack), 32'd0);
               acks++;
               ack_obs = obs;
               ack_data = o_data;
               ack_err = o_err;
               req_valid = 1'b0;
            end
            prev_ack = o_ack;
            if (err_drive >= 0 && obs == err_drive + 1) check("err_cyc_drop", 32'(wb_cyc), 32'd0);
            if (rst_done && obs == rst_obs + 1) begin
               check("rst_cyc", 32'(wb_cyc), 32'd0);
               check("rst_ack", 32'(o_ack), 32'd0);
               check("rst_outs", {o_err, wb_stb, wb_8_burst, o_data}, 32'd0);
               check("rst_adr", wb_adr, 32'd0);
            end
         end
         flush = (obs == 0 && flush_beat == -2);
         wb_ack = 1'b0;
         wb_err = 1'b0;
         i_rst = 1'b0;
         if (wb_cyc) begin
            saw_cyc = 1'b1;
            check("wb_adr", wb_adr, base + AW'(beats));
            check("wb_burst", {wb_stb, wb_8_burst}, 32'd3);
            if (beats == rst_beat && !rst_done) begin
               i_rst = 1'b1;
               rst_done = 1'b1;
               rst_obs = obs;
               req_valid = 1'b0;
            end else begin
               if (beats == flush_beat && !flushed) begin
                  flush = 1'b1;
                  flushed = 1'b1;
               end
               if (wcnt < waits) wcnt++;
               else begin
                  wcnt = 0;
                  if (beats == err_beat) begin
                     wb_err = 1'b1;
                     err_drive = obs;
                  end else begin
                     wb_ack = 1'b1;
                     wb_i_dat = mem(base + AW'(beats));
                     fill_line[beats] = wb_i_dat;
                     if (beats == off) drive_off = obs;
                     if (beats == 7) drive_last = obs;
                     beats++;
                  end
               end
            end
         end
         step();
         obs++;
         if ((acks > 0 || rst_done) && !wb_cyc && !o_ack && !req_valid) quiet++;
         else quiet = 0;
      end
      flush = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; i_rst = 1'b0; req_valid = 1'b0;
      check("finished", quiet, 4);
      // Expected outcome from the line rules.
      err_hit = (err_beat >= 0 && err_beat < 8);
      served_early = EARLY && (!err_hit || err_beat > off) && (rst_beat < 0 || rst_beat > off);
      exp_acks = 1; exp_err = 1'b0; exp_obs = 1;
      if (!hit) begin
         if (rst_beat >= 0 && !served_early) exp_acks = 0;
         else if (err_hit && !served_early) begin exp_err = 1'b1; exp_obs = err_drive + 1; end
         else if (served_early) exp_obs = drive_off + 1;
         else if (flushed) exp_obs = drive_last + 1;
         else exp_obs = drive_last + 2;
      end
      check("acks", acks, exp_acks);
      check("burst_seen", 32'(saw_cyc), 32'(!hit));
      if (exp_acks == 1) begin
         check("ack_latency", ack_obs, exp_obs);
         check("ack_err", 32'(ack_err), 32'(exp_err));
         if (!exp_err) check("data", ack_data, exp_data);
      end
      if (!hit && !err_hit && !rst_done) check("beats", beats, 8);
      if (hit) begin
         if (flush_beat == -2) m_valid = 1'b0;
      end else if (rst_done || err_hit || flushed) m_valid = 1'b0;
      else begin
         m_valid = 1'b1;
         m_tag = t;
         for (int i = 0; i < 8; i++) m_line[i] = fill_line[i];
      end
   endtask

   initial begin
      int n;
      logic [AW-1:0] ra;
      // Reset state
      i_rst = 1'b1;
      step();
      step();
      check("reset_ctl", {o_ack, o_err, wb_cyc, wb_stb, wb_8_burst}, 32'd0);
      check("reset_data", o_data, 32'd0);
      check("reset_adr", wb_adr, 32'd0);
      i_rst = 1'b0;
      step();
      fetch(24'h000010, 0, -1, -1, -1);
      // Miss then hit
      flush_idle();
      fetch(24'h000013, 0, -1, -1, -1);
      fetch(24'h000017, 0, -1, -1, -1);
      // Flush mid-fill, then re-request
      salt = 16'hB000;
      fetch(24'h000025, 0, -1, 3, -1);
      fetch(24'h000025, 0, -1, -1, -1);
      fetch(24'h000021, 0, -1, -1, -1);
      // Flush together with a hit
      fetch(24'h000024, 0, -1, -2, -1);
      salt = 16'hB100;
      fetch(24'h000024, 0, -1, -1, -1);
      // Bus error, then refill
      salt = 16'hC000;
      fetch(24'h000035, 0, 2, -1, -1);
      fetch(24'h000035, 0, -1, -1, -1);
      // Reset mid-fill, then miss again
      fetch(24'h000046, 0, -1, -1, 4);
      fetch(24'h000046, 0, -1, -1, -1);
      // Wait states, then read back the whole line
      salt = 16'hD000;
      fetch(24'h000051, 3, -1, -1, -1);
      for (int i = 0; i < 8; i++) fetch(24'h000050 + AW'(i), 0, -1, -1, -1);
      // Held request on a hit line: one response every other cycle
      req_addr = 24'h000052;
      req_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("b2b_cyc", 32'(wb_cyc), 32'd0);
         if (o_ack) begin
            n++;
            check("b2b_data", o_data, m_line[2]);
         end
      end
      req_valid = 1'b0;
      check("b2b_acks", n, 3);
      step();
      step();
      // Randomized fetches
      for (int k = 0; k < 40; k++) begin
         ra = {19'(0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
         salt = 16'($urandom);
         if ($urandom_range(0, 9) == 0) flush_idle();
         fetch(ra, $urandom_range(0, 2),
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1,
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1, -1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
